mbr_unit: RTL



---
 rtl/mbr_unit_if.sv | 30 +++
 rtl/mbr_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mbr_unit_if.sv
// mbr_unit_if: data-memory port of the MBR unit.
//   master (unit side):  drives mem_req, mem_we, mem_be, mem_wdata;
//                        receives mem_ack, mem_rdata.
//   slave (memory side): the mirror image.
// Handshake: the unit holds mem_req high with mem_we/mem_be/mem_wdata
// stable until it samples mem_ack high on a rising edge; read data on
// mem_rdata must be valid in that same cycle. mem_ack is ignored while
// mem_req is low.
interface mbr_unit_if #(
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mbr_unit.sv
// mbr_unit: memory buffer register with byte/half/word lane steering,
// sign/zero extension on loads, misalignment checks and an ack timeout.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus_load      load bus_in into the MBR (IDLE only, no command pending)
//   bus_in        internal data bus
//   cpu_ld/cpu_st start a memory read into / write of the MBR
//   cpu_size      log2(bytes) of the access
//   cpu_off       byte offset within the word
//   cpu_signed    sign-extend loaded data
//   mbr_out       MBR contents
//   busy          unit not in IDLE
//   done, err     one-cycle completion / error pulses
//   mem           data-memory port (mbr_unit_if.master)
//   state_dbg     current FSM state
// All outputs are registered.
module mbr_unit #(
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 15,
  localparam int BE_W    = DATA_W / 8,
  localparam int OFF_W   = (BE_W > 1) ? $clog2(BE_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_load,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              cpu_ld,
  input  logic              cpu_st,
  input  logic [1:0]        cpu_size,
  input  logic [OFF_W-1:0]  cpu_off,
  input  logic              cpu_signed,
  output logic [DATA_W-1:0] mbr_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  mbr_unit_if.master        mem,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] mbr;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        lat_size;
  logic [OFF_W-1:0]  lat_off;
  logic              lat_signed;
  logic              req_q, we_q, busy_q, done_q, err_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept, reject, timeout_hit;

  function automatic logic [BE_W-1:0] lane_be(input logic [1:0] size,
                                               input logic [OFF_W-1:0] off);
    logic [BE_W-1:0] be;
    int n, o;
    n  = 1 << size;
    o  = int'(off);
    be = '0;
    for (int i = 0; i < BE_W; i++)
      if (i >= o && i < o + n) be[i] = 1'b1;
    return be;
  endfunction

  // Low n bytes of d moved up to byte lane off; other lanes zero.
  function automatic logic [DATA_W-1:0] steer_w(input logic [DATA_W-1:0] d,
                                                input logic [1:0] size,
                                                input logic [OFF_W-1:0] off);
    logic [DATA_W-1:0] r;
    int n, o;
    n = 1 << size;
    o = int'(off);
    r = '0;
    for (int j = 0; j < BE_W; j++)
      if (j < n && j + o < BE_W) r[8*(j+o) +: 8] = d[8*j +: 8];
    return r;
  endfunction

  // Field of n bytes at lane off, extended to DATA_W.
  function automatic logic [DATA_W-1:0] extract_r(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic sgn);
    logic [DATA_W-1:0] r;
    logic fill;
    int n, o;
    n = 1 << size;
    o = int'(off);
    r = '0;
    for (int j = 0; j < BE_W; j++)
      if (j < n && j + o < BE_W) r[8*j +: 8] = d[8*(j+o) +: 8];
    if (n < BE_W) begin
      fill = sgn & r[8*n-1];
      for (int j = 0; j < BE_W; j++)
        if (j >= n) r[8*j +: 8] = {8{fill}};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    int req_n;
    next_state  = state;
    accept      = 1'b0;
    reject      = 1'b0;
    timeout_hit = 1'b0;
    req_n       = 1 << cpu_size;
    case (state)
      IDLE: begin
        if (cpu_ld || cpu_st) begin
          if ((cpu_ld && cpu_st) || req_n > BE_W ||
              (int'(cpu_off) & (req_n - 1)) != 0) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem.mem_ack) begin
          next_state = DONE;
        end else if (TIMEOUT != 0 && cnt == CNT_W'(TO_LAST)) begin
          next_state  = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mbr        <= '0;
      cnt        <= '0;
      lat_size   <= '0;
      lat_off    <= '0;
      lat_signed <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      busy_q <= (next_state != IDLE);
      req_q  <= (next_state == WAIT);
      // DONE is only entered from WAIT, so this is the completion cycle.
      done_q <= reject || (state == WAIT && next_state == DONE);
      err_q  <= reject || timeout_hit;

      if (accept) begin
        lat_size   <= cpu_size;
        lat_off    <= cpu_off;
        lat_signed <= cpu_signed;
        we_q       <= cpu_st;
        be_q       <= lane_be(cpu_size, cpu_off);
        wdata_q    <= cpu_st ? steer_w(mbr, cpu_size, cpu_off) : '0;
        cnt        <= '0;
      end else if (next_state != WAIT) begin
        we_q    <= 1'b0;
        be_q    <= '0;
        wdata_q <= '0;
      end

      if (state == WAIT) cnt <= cnt + 1'b1;

      if (state == IDLE && bus_load && !cpu_ld && !cpu_st)
        mbr <= bus_in;
      else if (state == WAIT && mem.mem_ack && !we_q)
        mbr <= extract_r(mem.mem_rdata, lat_size, lat_off, lat_signed);
    end
  end

  assign mbr_out       = mbr;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign state_dbg     = state;

endmodule
